// File: rtl/id_stage_pipelined_if.sv
// ID stage bus: IF-side request, pipeline hazard inputs, writeback/status update
// ports and the registered ID/EXE outputs. slave = the ID stage, master = its environment.
interface id_stage_pipelined_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] pc_in;
   logic [31:0]       instruction;
   logic              flush;
   logic [3:0]        exe_dest;
   logic              exe_wb_en;
   logic              exe_mem_r_en;
   logic [3:0]        mem_dest;
   logic              mem_wb_en;
   logic              wb_en_in;
   logic [3:0]        wb_dest;
   logic [DATA_W-1:0] wb_value;
   logic              status_w_en;
   logic [3:0]        status_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] pc_out;
   logic              mem_r_en;
   logic              mem_w_en;
   logic              wb_en;
   logic              s_out;
   logic              branch_taken;
   logic              imm;
   logic [3:0]        exec_cmd;
   logic [DATA_W-1:0] val_rn;
   logic [DATA_W-1:0] val_rm;
   logic [11:0]       shift_operand;
   logic [23:0]       signed_immed_24;
   logic [3:0]        dest;
   logic [3:0]        src1;
   logic [3:0]        src2;

   modport slave (
      input  in_valid, pc_in, instruction, flush,
      input  exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
      input  wb_en_in, wb_dest, wb_value, status_w_en, status_in, out_ready,
      output in_ready, out_valid, pc_out, mem_r_en, mem_w_en, wb_en, s_out,
      output branch_taken, imm, exec_cmd, val_rn, val_rm, shift_operand,
      output signed_immed_24, dest, src1, src2
   );

   modport master (
      output in_valid, pc_in, instruction, flush,
      output exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
      output wb_en_in, wb_dest, wb_value, status_w_en, status_in, out_ready,
      input  in_ready, out_valid, pc_out, mem_r_en, mem_w_en, wb_en, s_out,
      input  branch_taken, imm, exec_cmd, val_rn, val_rm, shift_operand,
      input  signed_immed_24, dest, src1, src2
   );
endinterface

// File: rtl/id_stage_pipelined.sv
// ARM-subset decode stage: decode, regfile read, condition check, RAW hazard stall,
// registered ID/EXE output. Define ID_FORWARDING_EN to stall only on load-use.
module id_stage_pipelined #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input logic                 clk,
   input logic                 rst,
   id_stage_pipelined_if.slave bus
);

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic              mem_r_en;
      logic              mem_w_en;
      logic              wb_en;
      logic              s_out;
      logic              branch_taken;
      logic              imm;
      logic [3:0]        exec_cmd;
      logic [DATA_W-1:0] val_rn;
      logic [DATA_W-1:0] val_rm;
      logic [11:0]       shift_operand;
      logic [23:0]       signed_immed_24;
      logic [3:0]        dest;
      logic [3:0]        src1;
      logic [3:0]        src2;
   } id_exe_t;

   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic [DATA_W-1:0] rf_d [NUM_REGS];
   logic [3:0]        status_q, status_d;
   id_exe_t           pipe_q, pipe_d;
   logic              out_valid_q, out_valid_d;

   logic [3:0] cond, opcode, rn, rd, rm, src2;
   logic [1:0] mode;
   logic       i_bit, s_bit;
   assign cond   = bus.instruction[31:28];
   assign mode   = bus.instruction[27:26];
   assign i_bit  = bus.instruction[25];
   assign opcode = bus.instruction[24:21];
   assign s_bit  = bus.instruction[20];
   assign rn     = bus.instruction[19:16];
   assign rd     = bus.instruction[15:12];
   assign rm     = bus.instruction[3:0];

   // Read port with write-through so a same-cycle writeback is seen by this decode.
   function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] a);
      if ({1'b0, a} >= 5'(NUM_REGS))                return '0;
      else if (bus.wb_en_in && (bus.wb_dest == a))  return bus.wb_value;
      else                                          return rf_q[a];
   endfunction

   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
      logic n, z, cf, v;
      {n, z, cf, v} = nzcv;
      case (c)
         4'h0:    return z;
         4'h1:    return ~z;
         4'h2:    return cf;
         4'h3:    return ~cf;
         4'h4:    return n;
         4'h5:    return ~n;
         4'h6:    return v;
         4'h7:    return ~v;
         4'h8:    return cf & ~z;
         4'h9:    return ~cf | z;
         4'hA:    return n == v;
         4'hB:    return n != v;
         4'hC:    return ~z & (n == v);
         4'hD:    return z | (n != v);
         4'hE:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   logic       dec_mem_r, dec_mem_w, dec_wb, dec_s, dec_br, dec_imm;
   logic [3:0] dec_cmd;
   logic       is_cmp_tst, known;

   always_comb begin
      dec_mem_r  = 1'b0;
      dec_mem_w  = 1'b0;
      dec_wb     = 1'b0;
      dec_s      = 1'b0;
      dec_br     = 1'b0;
      dec_imm    = 1'b0;
      dec_cmd    = 4'h0;
      is_cmp_tst = 1'b0;
      known      = 1'b1;
      case (mode)
         2'b00: begin
            case (opcode)
               4'b1101: dec_cmd = 4'b0001;
               4'b1111: dec_cmd = 4'b1001;
               4'b0100: dec_cmd = 4'b0010;
               4'b0101: dec_cmd = 4'b0011;
               4'b0010: dec_cmd = 4'b0100;
               4'b0110: dec_cmd = 4'b0101;
               4'b0000: dec_cmd = 4'b0110;
               4'b1100: dec_cmd = 4'b0111;
               4'b0001: dec_cmd = 4'b1000;
               4'b1010: begin dec_cmd = 4'b0100; is_cmp_tst = 1'b1; end
               4'b1000: begin dec_cmd = 4'b0110; is_cmp_tst = 1'b1; end
               default: known = 1'b0;
            endcase
            if (known) begin
               dec_wb  = ~is_cmp_tst;
               dec_s   = s_bit | is_cmp_tst;
               dec_imm = i_bit;
            end
         end
         2'b01: begin
            dec_cmd   = 4'b0010;
            dec_imm   = i_bit;
            dec_mem_r = s_bit;
            dec_wb    = s_bit;
            dec_mem_w = ~s_bit;
         end
         2'b10: begin
            dec_br  = 1'b1;
            dec_imm = i_bit;
         end
         default: ;
      endcase
   end

   logic is_str, rn_used, src2_used, hazard, cond_ok, advance;
   assign is_str    = (mode == 2'b01) & ~s_bit;
   assign src2      = is_str ? rd : rm;
   assign rn_used   = ~(((mode == 2'b00) & ((opcode == 4'b1101) | (opcode == 4'b1111)))
                        | (mode == 2'b10));
   assign src2_used = ((mode == 2'b00) & ~i_bit) | is_str;
   assign cond_ok   = cond_pass(cond, status_q);

`ifdef ID_FORWARDING_EN
   // Only a load in EXE cannot be forwarded in time.
   assign hazard = bus.exe_wb_en & bus.exe_mem_r_en &
                   ((rn_used & (rn == bus.exe_dest)) | (src2_used & (src2 == bus.exe_dest)));
`else
   assign hazard = (bus.exe_wb_en & ((rn_used & (rn == bus.exe_dest)) |
                                     (src2_used & (src2 == bus.exe_dest)))) |
                   (bus.mem_wb_en & ((rn_used & (rn == bus.mem_dest)) |
                                     (src2_used & (src2 == bus.mem_dest))));
`endif

   assign advance      = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = rst & ~bus.flush & advance & ~hazard;

   id_exe_t dec;
   always_comb begin
      dec                 = '0;
      dec.pc              = bus.pc_in;
      dec.val_rn          = rf_read(rn);
      dec.val_rm          = rf_read(src2);
      dec.shift_operand   = bus.instruction[11:0];
      dec.signed_immed_24 = bus.instruction[23:0];
      dec.dest            = rd;
      dec.src1            = rn;
      dec.src2            = src2;
      // A failed condition still occupies the slot, just with no side effects.
      if (cond_ok) begin
         dec.mem_r_en     = dec_mem_r;
         dec.mem_w_en     = dec_mem_w;
         dec.wb_en        = dec_wb;
         dec.s_out        = dec_s;
         dec.branch_taken = dec_br;
         dec.imm          = dec_imm;
         dec.exec_cmd     = dec_cmd;
      end
   end

   always_comb begin
      pipe_d      = pipe_q;
      out_valid_d = out_valid_q;
      if (bus.flush) begin
         pipe_d      = '0;
         out_valid_d = 1'b0;
      end else if (advance) begin
         if (bus.in_valid && !hazard) begin
            pipe_d      = dec;
            out_valid_d = 1'b1;
         end else begin
            pipe_d      = '0;
            out_valid_d = 1'b0;
         end
      end
   end

   always_comb begin
      rf_d = rf_q;
      if (bus.wb_en_in && ({1'b0, bus.wb_dest} < 5'(NUM_REGS)))
         rf_d[bus.wb_dest] = bus.wb_value;
      status_d = bus.status_w_en ? bus.status_in : status_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
         status_q    <= '0;
         pipe_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         rf_q        <= rf_d;
         status_q    <= status_d;
         pipe_q      <= pipe_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out_valid       = out_valid_q;
   assign bus.pc_out          = pipe_q.pc;
   assign bus.mem_r_en        = pipe_q.mem_r_en;
   assign bus.mem_w_en        = pipe_q.mem_w_en;
   assign bus.wb_en           = pipe_q.wb_en;
   assign bus.s_out           = pipe_q.s_out;
   assign bus.branch_taken    = pipe_q.branch_taken;
   assign bus.imm             = pipe_q.imm;
   assign bus.exec_cmd        = pipe_q.exec_cmd;
   assign bus.val_rn          = pipe_q.val_rn;
   assign bus.val_rm          = pipe_q.val_rm;
   assign bus.shift_operand   = pipe_q.shift_operand;
   assign bus.signed_immed_24 = pipe_q.signed_immed_24;
   assign bus.dest            = pipe_q.dest;
   assign bus.src1            = pipe_q.src1;
   assign bus.src2            = pipe_q.src2;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed bench for id_stage_pipelined: vector table plus hand-written
// backpressure/flush, write-through, status-timing and reset sequences.
module tb_id_stage_pipelined;

`ifdef ID_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   id_stage_pipelined_if #(.DATA_W(32)) bus ();

   id_stage_pipelined #(.DATA_W(32), .NUM_REGS(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] ins;
      logic [3:0]  st;
      logic [3:0]  exe_dest;
      logic        exe_wb;
      logic        exe_ld;
      logic [3:0]  mem_dest;
      logic        mem_wb;
      logic        exp_rdy;
      logic        exp_vld;
      logic [3:0]  exp_cmd;
      logic [5:0]  exp_ctl;   // {mem_r, mem_w, wb, s, br, imm}
      logic [31:0] exp_rn;
      logic [31:0] exp_rm;
      logic [3:0]  exp_dest;
   } vec_t;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [3:0] a, input logic [31:0] v);
      bus.wb_en_in = 1'b1;
      bus.wb_dest  = a;
      bus.wb_value = v;
      step();
      bus.wb_en_in = 1'b0;
   endtask

   task automatic set_status(input logic [3:0] s);
      bus.status_w_en = 1'b1;
      bus.status_in   = s;
      step();
      bus.status_w_en = 1'b0;
   endtask

   function automatic logic [5:0] ctl_now();
      return {bus.mem_r_en, bus.mem_w_en, bus.wb_en, bus.s_out, bus.branch_taken, bus.imm};
   endfunction

   localparam logic [31:0] ADD = 32'hE0821003;
   localparam logic [31:0] EQA = 32'h00821003;

   vec_t tbl [20];

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //         ins           st     exd  ew ld  md  mw  rdy vld cmd  ctl        rn     rm     dst
      tbl[0]  = '{ADD,         4'h0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h2, 6'b001000, 32'h5, 32'h7,  4'h1};
      tbl[1]  = '{EQA,         4'h0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h0, 6'b000000, 32'h5, 32'h7,  4'h1};
      tbl[2]  = '{EQA,         4'h4, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h2, 6'b001000, 32'h5, 32'h7,  4'h1};
      tbl[3]  = '{32'hE0524003, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h4, 6'b001100, 32'h5, 32'h7,  4'h4};
      tbl[4]  = '{32'hE1520003, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h4, 6'b000100, 32'h5, 32'h7,  4'h0};
      tbl[5]  = '{32'hE3A05012, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h1, 6'b001001, 32'h0, 32'h5,  4'h5};
      tbl[6]  = '{32'hE5926004, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h2, 6'b101000, 32'h5, 32'h10, 4'h6};
      tbl[7]  = '{32'hE5823000, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h2, 6'b010000, 32'h5, 32'h7,  4'h3};
      tbl[8]  = '{32'hEA000004, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h0, 6'b000011, 32'h0, 32'h10, 4'h0};
      // EXE hazard on R2 (non-load): stall only without forwarding
      tbl[9]  = '{ADD,         4'h0, 4'h2, 1, 0, 4'h0, 0, FWD, FWD, FWD ? 4'h2 : 4'h0,
                  FWD ? 6'b001000 : 6'b000000, 32'h5, 32'h7, 4'h1};
      // load-use: stall in both builds
      tbl[10] = '{ADD,         4'h0, 4'h2, 1, 1, 4'h0, 0, 0, 0, 4'h0, 6'b000000, 32'h0, 32'h0,  4'h0};
      tbl[11] = '{ADD,         4'h0, 4'h0, 0, 0, 4'h3, 1, FWD, FWD, FWD ? 4'h2 : 4'h0,
                  FWD ? 6'b001000 : 6'b000000, 32'h5, 32'h7, 4'h1};
      // MOV imm: rn and rm unused, no stall on a matching load
      tbl[12] = '{32'hE3A05012, 4'h0, 4'h0, 1, 1, 4'h0, 0, 1, 1, 4'h1, 6'b001001, 32'h0, 32'h5,  4'h5};
      tbl[13] = '{32'hE3A05012, 4'h0, 4'h2, 1, 1, 4'h0, 0, 1, 1, 4'h1, 6'b001001, 32'h0, 32'h5,  4'h5};
      tbl[14] = '{32'hE0621003, 4'h0, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h0, 6'b000000, 32'h5, 32'h7,  4'h1};
      tbl[15] = '{32'hF0821003, 4'hF, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h0, 6'b000000, 32'h5, 32'h7,  4'h1};
      tbl[16] = '{32'hA0821003, 4'h9, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h2, 6'b001000, 32'h5, 32'h7,  4'h1};
      tbl[17] = '{32'hB0821003, 4'h9, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h0, 6'b000000, 32'h5, 32'h7,  4'h1};
      tbl[18] = '{32'h80821003, 4'h2, 4'h0, 0, 0, 4'h0, 0, 1, 1, 4'h2, 6'b001000, 32'h5, 32'h7,  4'h1};
      // STR reads rd(R3) as its second source
      tbl[19] = '{32'hE5823000, 4'h0, 4'h0, 0, 0, 4'h3, 1, FWD, FWD, FWD ? 4'h2 : 4'h0,
                  FWD ? 6'b010000 : 6'b000000, 32'h5, 32'h7, 4'h3};

      bus.in_valid = 0; bus.pc_in = '0; bus.instruction = '0; bus.flush = 0;
      bus.exe_dest = '0; bus.exe_wb_en = 0; bus.exe_mem_r_en = 0;
      bus.mem_dest = '0; bus.mem_wb_en = 0;
      bus.wb_en_in = 0; bus.wb_dest = '0; bus.wb_value = '0;
      bus.status_w_en = 0; bus.status_in = '0; bus.out_ready = 1;

      step();
      step();
      chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
      chk("reset_in_ready",  32'(bus.in_ready),  32'h0);
      chk("reset_exec_cmd",  32'(bus.exec_cmd),  32'h0);
      chk("reset_pc_out",    bus.pc_out,         32'h0);
      rst = 1'b1;

      wb_write(4'd2, 32'h5);
      wb_write(4'd3, 32'h7);
      wb_write(4'd4, 32'h10);

      for (int i = 0; i < 20; i++) begin
         set_status(tbl[i].st);
         bus.exe_dest     = tbl[i].exe_dest;
         bus.exe_wb_en    = tbl[i].exe_wb;
         bus.exe_mem_r_en = tbl[i].exe_ld;
         bus.mem_dest     = tbl[i].mem_dest;
         bus.mem_wb_en    = tbl[i].mem_wb;
         bus.instruction  = tbl[i].ins;
         bus.pc_in        = 32'h100 + 32'(i * 4);
         bus.in_valid     = 1'b1;
         #1;
         chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_rdy));
         step();
         bus.in_valid = 1'b0; bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0; bus.mem_wb_en = 1'b0;
         chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_vld));
         chk($sformatf("v%0d_exec_cmd", i),  32'(bus.exec_cmd),  32'(tbl[i].exp_cmd));
         chk($sformatf("v%0d_ctl", i),       32'(ctl_now()),     32'(tbl[i].exp_ctl));
         if (tbl[i].exp_vld) begin
            chk($sformatf("v%0d_val_rn", i), bus.val_rn,         tbl[i].exp_rn);
            chk($sformatf("v%0d_val_rm", i), bus.val_rm,         tbl[i].exp_rm);
            chk($sformatf("v%0d_dest", i),   32'(bus.dest),      32'(tbl[i].exp_dest));
            chk($sformatf("v%0d_pc", i),     bus.pc_out,         32'h100 + 32'(i * 4));
            chk($sformatf("v%0d_imm24", i),  32'(bus.signed_immed_24), 32'(tbl[i].ins[23:0]));
            chk($sformatf("v%0d_src1", i),   32'(bus.src1),      32'(tbl[i].ins[19:16]));
         end
      end

      // backpressure holds the ADD, then flush drops it
      bus.instruction = ADD; bus.pc_in = 32'h300; bus.in_valid = 1'b1;
      step();
      chk("bp_first_valid", 32'(bus.out_valid), 32'h1);
      bus.out_ready = 1'b0; bus.instruction = 32'hE0524003; bus.pc_in = 32'h304;
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      step();
      step();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_hold_cmd",   32'(bus.exec_cmd),  32'h2);
      chk("bp_hold_pc",    bus.pc_out,         32'h300);
      chk("bp_hold_dest",  32'(bus.dest),      32'h1);
      bus.flush = 1'b1;
      #1;
      chk("flush_in_ready", 32'(bus.in_ready), 32'h0);
      step();
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      chk("flush_out_valid", 32'(bus.out_valid), 32'h0);
      chk("flush_cmd",       32'(bus.exec_cmd),  32'h0);
      chk("flush_wb_en",     32'(bus.wb_en),     32'h0);

      // same-cycle writeback of R3 is visible to the decode, then stored
      bus.wb_en_in = 1'b1; bus.wb_dest = 4'd3; bus.wb_value = 32'hA5;
      bus.instruction = ADD; bus.in_valid = 1'b1;
      step();
      bus.wb_en_in = 1'b0;
      chk("wt_val_rm", bus.val_rm, 32'hA5);
      step();
      bus.in_valid = 1'b0;
      chk("wt_stored_val_rm", bus.val_rm, 32'hA5);

      // condition uses the status value from before this cycle's update
      set_status(4'h0);
      bus.status_w_en = 1'b1; bus.status_in = 4'h4;
      bus.instruction = EQA; bus.in_valid = 1'b1;
      step();
      bus.status_w_en = 1'b0;
      chk("st_pre_valid", 32'(bus.out_valid), 32'h1);
      chk("st_pre_cmd",   32'(bus.exec_cmd),  32'h0);
      step();
      bus.in_valid = 1'b0;
      chk("st_post_cmd",  32'(bus.exec_cmd),  32'h2);

      // asynchronous reset mid-cycle
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("arst_cmd",       32'(bus.exec_cmd),  32'h0);
      chk("arst_val_rn",    bus.val_rn,         32'h0);
      chk("arst_in_ready",  32'(bus.in_ready),  32'h0);
      step();
      rst = 1'b1;
      bus.instruction = ADD; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk("arst_rf_cleared_rn", bus.val_rn, 32'h0);
      chk("arst_rf_cleared_rm", bus.val_rm, 32'h0);
      chk("arst_recover_valid", 32'(bus.out_valid), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised successor of the ARM decode stage.
- Decodes one instruction per cycle, reads an internal register file (with writeback port), and checks the condition against an internal NZCV status register.
- Detects RAW hazards against the EXE and MEM stages; stalls IF and inserts bubbles when a hazard is found.
- Drives a registered ID/EXE pipeline register with a valid/ready handshake and flush.
- Sits between the IF stage and the EXE stage.

Parameters:
- DATA_W, 32, register/PC/operand width.
- NUM_REGS, 16, register file depth (≤16; address field fixed at 4 bits).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IF presents an instruction
- in_ready  out  1  ID accepts it this cycle
- pc_in  in  DATA_W  PC of the instruction
- instruction  in  32  instruction word
- flush  in  1  branch taken in EXE; kill ID contents
- exe_dest  in  4  EXE-stage destination
- exe_wb_en  in  1  EXE-stage writes back
- exe_mem_r_en  in  1  EXE-stage instruction is a load
- mem_dest  in  4  MEM-stage destination
- mem_wb_en  in  1  MEM-stage writes back
- wb_en_in  in  1  register file write enable
- wb_dest  in  4  register file write address
- wb_value  in  DATA_W  register file write data
- status_w_en  in  1  update status register
- status_in  in  4  NZCV from EXE
- out_valid  out  1  ID/EXE register holds an instruction
- out_ready  in  1  EXE accepts
- pc_out  out  DATA_W  PC
- mem_r_en, mem_w_en, wb_en, s_out, branch_taken, imm  out  1 each  control
- exec_cmd  out  4  ALU command
- val_rn, val_rm  out  DATA_W  operands
- shift_operand  out  12  instruction[11:0]
- signed_immed_24  out  24  instruction[23:0]
- dest  out  4  instruction[15:12]
- src1, src2  out  4  operand register numbers, for forwarding

Behaviour:
- Reset (rst=0, async): all outputs 0; out_valid=0; status=0; all registers 0.
- Instruction fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], rn[19:16], rd[15:12], rm[3:0].
- mode=00 exec_cmd mapping (opcode→cmd):
  - MOV 1101→0001, MVN 1111→1001
  - ADD 0100→0010, ADC 0101→0011
  - SUB 0010→0100, SBC 0110→0101
  - AND 0000→0110, ORR 1100→0111, EOR 0001→1000
  - CMP 1010→0100, TST 1000→0110
  - wb_en=1 except CMP/TST; s_out=S, forced 1 for CMP/TST.
- mode=01 (memory): exec_cmd=0010; S=1 → LDR (mem_r_en=1, wb_en=1); S=0 → STR (mem_w_en=1).
- mode=10: branch_taken=1, all others 0. imm=I.
- Unknown opcode: all control 0.
- Condition check: standard ARM EQ..AL (0000–1110) evaluated on current status; 1111 → false.
  - On failure, control bits and exec_cmd are forced 0 (bubble), but out_valid still asserts.
- Operand addressing: src1=rn; src2 = rd for STR, else rm.
- Operand usage:
  - rn used unless MOV/MVN or branch.
  - src2 used when (mode=00 and I=0) or STR.
- Hazard (no forwarding): a used source equals exe_dest with exe_wb_en=1, or equals mem_dest with mem_wb_en=1.
- Register file:
  - Write on rising clk when wb_en_in=1 and wb_dest<NUM_REGS.
  - Reads are combinational with write-through: same-cycle wb_dest match returns wb_value.
  - Addresses ≥NUM_REGS read 0.
- Status register: updated on rising clk when status_w_en=1. The condition check uses the pre-update value in that cycle.
- Handshake:
  - advance = ~out_valid | out_ready.
  - in_ready = advance & ~hazard.
  - On advance: if in_valid & ~hazard, load the decoded instruction and set out_valid=1; otherwise load a bubble (all controls 0, out_valid=0).
  - Without advance, all outputs hold.
- flush (highest priority): next edge out_valid=0 and controls 0; in_ready=0 that cycle; the current instruction is dropped.
- Latency: 1 cycle from acceptance to out_valid.

Optional Feature:
- Macro: ID_FORWARDING_EN.
- Defined: hazard = used source matches exe_dest with exe_wb_en=1 and exe_mem_r_en=1 (load-use only). MEM-stage matches do not stall; src1/src2 feed the EXE forwarding unit.
- Undefined: full hazard rule above; src1/src2 still driven.

Test Plan:
- Reset, then write R2=5, R3=7 via WB; present 0xE0821003 (ADD R1,R2,R3) → next cycle out_valid=1, exec_cmd=0010, wb_en=1, val_rn=5, val_rm=7, dest=1.
- status=0000, present 0x00821003 (EQ) → out_valid=1, all control bits and exec_cmd 0.
- exe_dest=2, exe_wb_en=1, exe_mem_r_en=0, present ADD above → in_ready=0, bubble issued.
  - With ID_FORWARDING_EN: no stall.
  - With exe_mem_r_en=1: 1-cycle stall in both builds.
- Present 0xEA000004 (B) → branch_taken=1, signed_immed_24=0x000004, wb_en=0.
- out_ready=0 with an instruction held → outputs stable, in_ready=0. Then flush=1 → next cycle out_valid=0.
- Same cycle: wb_en_in=1, wb_dest=3, wb_value=0xA5 and ADD reading R3 → val_rm=0xA5. Assert rst mid-stream → outputs 0 immediately.
